// File: rtl/monitor_uart_tx.sv
// monitor_uart_tx: pops 128-bit monitor words from the upstream single-entry
// register and serializes each as 16 UART frames (start, 8 data LSB first,
// even parity, stop bits, idle gap bits), most significant byte first.
module monitor_uart_tx #(
  parameter int BIT_TICKS = 8,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INHIBIT,
  input  logic [127:0] MONITOR_FIFO_DATA,
  input  logic         MONITOR_FIFO_EMPTY,
  output logic         MONITOR_FIFO_READ,
  output logic         UART_TX,
  output logic         BUSY,
  output logic [15:0]  WORDS_SENT
);

  localparam logic [15:0] TICK_LAST = 16'(BIT_TICKS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_BITS - 1);
  localparam bit          GAP_EN    = (GAP_BITS != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t         state_q;
  logic [127:0]   shift_q;   // byte in flight always sits in [127:120]
  logic [15:0]    tick_q;    // cycles elapsed within the current bit
  logic [3:0]     bit_q;     // bit index within the current state
  logic [3:0]     byte_q;    // byte index within the word
  logic           tx_q;
  logic           read_q;
  logic           busy_q;
  logic [15:0]    words_q;

  logic [7:0]     cur_byte;
  logic           tick_last;
  logic [2:0]     next_bit_idx;
  logic           frame_last_bit;

  assign cur_byte     = shift_q[127:120];
  assign tick_last    = (tick_q == TICK_LAST);
  assign next_bit_idx = bit_q[2:0] + 3'd1;

  // The frame ends on the last stop bit when there is no gap, otherwise on
  // the last gap bit.
  assign frame_last_bit = GAP_EN ? ((state_q == S_GAP) && (bit_q == GAP_LAST))
                                 : ((state_q == S_STOP) && (bit_q == STOP_LAST));

  // Frame sequencer: pop, bit timing, byte stepping and word completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      words_q <= '0;
    end else begin
      read_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!MONITOR_FIFO_EMPTY && !INHIBIT) begin
            // Latch now: the upstream may reload while READ is high.
            shift_q <= MONITOR_FIFO_DATA;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            state_q <= S_START;
          end else begin
            tx_q <= 1'b1;
          end
        end
        default: begin
          if (!tick_last) begin
            tick_q <= tick_q + 16'd1;
          end else begin
            tick_q <= '0;
            if (frame_last_bit) begin
              bit_q <= '0;
              if (byte_q == 4'd15) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                words_q <= words_q + 16'd1;
                tx_q    <= 1'b1;
              end else begin
                // Next frame starts immediately with its start bit.
                byte_q  <= byte_q + 4'd1;
                shift_q <= {shift_q[119:0], 8'h00};
                state_q <= S_START;
                tx_q    <= 1'b0;
              end
            end else begin
              case (state_q)
                S_START: begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
                  tx_q    <= cur_byte[0];
                end
                S_DATA: begin
                  if (bit_q == 4'd7) begin
                    state_q <= S_PARITY;
                    tx_q    <= ^cur_byte;
                  end else begin
                    bit_q <= bit_q + 4'd1;
                    tx_q  <= cur_byte[next_bit_idx];
                  end
                end
                S_PARITY: begin
                  state_q <= S_STOP;
                  bit_q   <= '0;
                  tx_q    <= 1'b1;
                end
                S_STOP: begin
                  // Last stop bit without gap is handled as frame end above.
                  if (bit_q == STOP_LAST) begin
                    state_q <= S_GAP;
                    bit_q   <= '0;
                  end else begin
                    bit_q <= bit_q + 4'd1;
                  end
                  tx_q <= 1'b1;
                end
                S_GAP: begin
                  bit_q <= bit_q + 4'd1;
                  tx_q  <= 1'b1;
                end
                default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  tx_q    <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign MONITOR_FIFO_READ = read_q;
  assign UART_TX           = tx_q;
  assign BUSY              = busy_q;
  assign WORDS_SENT        = words_q;

endmodule
